// File: rtl/twi_frame_scheduler.sv
// TWI frame queue feeding a UART frame presenter: circular FIFO plus a three-state issue handshake.
// Optional per-drop counter enabled by defining TWI_SCHED_DROP_COUNT_EN.
module twi_frame_scheduler #(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [17:0]   frame_in,
    input  logic          frame_valid,
    input  logic          flush,
    input  logic          tx_available,
    output logic [17:0]   frame_out,
    output logic          new_data_ready,
    output logic [CW-1:0] fifo_count,
    output logic          fifo_empty,
    output logic          fifo_full,
`ifdef TWI_SCHED_DROP_COUNT_EN
    output logic [7:0]    drop_count,
`endif
    output logic          overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [17:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [17:0]     frame_out_reg;
    logic            overflow_reg;
    logic            pop, push_ok, drop;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CW'(DEPTH));

    // A flush cycle neither pops nor pushes; the in-flight frame is untouched.
    assign pop     = (state_reg == IDLE) && !fifo_empty && tx_available && !flush;
    assign push_ok = frame_valid && !flush && (!fifo_full || pop);
    assign drop    = frame_valid && !flush && fifo_full && !pop;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pop) state_next = ISSUE;
            ISSUE:   if (!tx_available) state_next = BUSY;
            BUSY:    if (tx_available) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Storage carries no reset; validity is tracked entirely by pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= frame_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            frame_out_reg <= '0;
        end else begin
            if (pop) begin
                frame_out_reg <= mem[rd_ptr_reg];
            end
            if (flush) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                count_reg    <= '0;
                overflow_reg <= 1'b0;
            end else begin
                if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
                if (push_ok && !pop)      count_reg <= count_reg + CW'(1);
                else if (pop && !push_ok) count_reg <= count_reg - CW'(1);
                if (drop) overflow_reg <= 1'b1;
            end
        end
    end

`ifdef TWI_SCHED_DROP_COUNT_EN
    logic [7:0] drop_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_reg <= '0;
        end else if (flush) begin
            drop_count_reg <= '0;
        end else if (drop && drop_count_reg != 8'hFF) begin
            drop_count_reg <= drop_count_reg + 8'd1;
        end
    end

    assign drop_count = drop_count_reg;
`endif

    assign frame_out      = frame_out_reg;
    assign new_data_ready = (state_reg == ISSUE);
    assign fifo_count     = count_reg;
    assign overflow       = overflow_reg;

endmodule

// File: tb/tb_twi_frame_scheduler.sv
// Directed plus randomized bench for twi_frame_scheduler against a queue-based presenter model.
// Honours TWI_SCHED_DROP_COUNT_EN the same way as the design.
module tb_twi_frame_scheduler;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [17:0]   frame_in;
    logic          frame_valid;
    logic          flush;
    logic          tx_available;
    logic [17:0]   frame_out;
    logic          new_data_ready;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          overflow;
`ifdef TWI_SCHED_DROP_COUNT_EN
    logic [7:0]    drop_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model: queued frames, presenter handshake phase, and sticky status.
    logic [17:0] mq[$];
    bit          m_issuing, m_waiting;
    logic [17:0] m_out;
    bit          m_ovf;
    int          m_dc;

    twi_frame_scheduler #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .frame_in       (frame_in),
        .frame_valid    (frame_valid),
        .flush          (flush),
        .tx_available   (tx_available),
        .frame_out      (frame_out),
        .new_data_ready (new_data_ready),
        .fifo_count     (fifo_count),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
`ifdef TWI_SCHED_DROP_COUNT_EN
        .drop_count     (drop_count),
`endif
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_issuing = 0;
        m_waiting = 0;
        m_out     = '0;
        m_ovf     = 0;
        m_dc      = 0;
    endtask

    task automatic model_step(input bit v, input logic [17:0] f, input bit fl, input bit tx);
        bit idle, do_pop;
        idle   = !m_issuing && !m_waiting;
        do_pop = idle && mq.size() > 0 && tx && !fl;
        if (fl) begin
            mq.delete();
            m_ovf = 0;
            m_dc  = 0;
        end else begin
            if (do_pop) m_out = mq.pop_front();
            if (v) begin
                if (mq.size() < DEPTH) mq.push_back(f);
                else begin
                    m_ovf = 1;
                    if (m_dc < 255) m_dc++;
                end
            end
        end
        if (idle) begin
            if (do_pop) m_issuing = 1;
        end else if (m_issuing) begin
            if (!tx) begin m_issuing = 0; m_waiting = 1; end
        end else if (tx) begin
            m_waiting = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".frame_out"}, 32'(frame_out), 32'(m_out));
        chk({tag, ".ndr"},       32'(new_data_ready), 32'(m_issuing));
        chk({tag, ".count"},     32'(fifo_count), 32'(mq.size()));
        chk({tag, ".empty"},     32'(fifo_empty), 32'(mq.size() == 0));
        chk({tag, ".full"},      32'(fifo_full), 32'(mq.size() == DEPTH));
        chk({tag, ".overflow"},  32'(overflow), 32'(m_ovf));
`ifdef TWI_SCHED_DROP_COUNT_EN
        chk({tag, ".drop_count"}, 32'(drop_count), 32'(m_dc));
`endif
    endtask

    task automatic cycle(input string tag, input bit v, input logic [17:0] f, input bit fl, input bit tx);
        frame_valid  = v;
        frame_in     = f;
        flush        = fl;
        tx_available = tx;
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step(v, f, fl, tx);
        #1;
        $display("cyc %s v=%0b f=%05h fl=%0b tx=%0b -> out=%05h ndr=%0b cnt=%0d ovf=%0b",
                 tag, v, f, fl, tx, frame_out, new_data_ready, fifo_count, overflow);
        check_all(tag);
    endtask

    // Walk the presenter through one issue/complete handshake.
    task automatic handshake(input string tag);
        cycle(tag, 0, '0, 0, 1);
        cycle(tag, 0, '0, 0, 0);
        cycle(tag, 0, '0, 0, 1);
    endtask

    initial begin
        reset_n = 1'b0; frame_in = '0; frame_valid = 0; flush = 0; tx_available = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset_n = 1'b1;

        // Single frame
        cycle("t1_push", 1, 18'h2A5F3, 0, 1);
        chk("t1_count1", 32'(fifo_count), 32'd1);
        cycle("t1_pop", 0, '0, 0, 1);
        chk("t1_ndr", 32'(new_data_ready), 32'd1);
        chk("t1_frame", 32'(frame_out), 32'h2A5F3);
        cycle("t1_busy", 0, '0, 0, 0);
        cycle("t1_done", 0, '0, 0, 1);
        chk("t1_ndr_low", 32'(new_data_ready), 32'd0);
        chk("t1_empty", 32'(fifo_empty), 32'd1);

        // Burst of three while the presenter is busy elsewhere
        cycle("t2_a", 1, 18'h11111, 0, 0);
        cycle("t2_b", 1, 18'h22222, 0, 0);
        cycle("t2_c", 1, 18'h33333, 0, 0);
        chk("t2_count3", 32'(fifo_count), 32'd3);
        repeat (3) handshake("t2_drain");

        // Overflow: ten pushes into eight slots
        for (int i = 0; i < 10; i++) cycle("t3_push", 1, 18'(18'h100 + i), 0, 0);
        chk("t3_full", 32'(fifo_full), 32'd1);
        chk("t3_ovf", 32'(overflow), 32'd1);
`ifdef TWI_SCHED_DROP_COUNT_EN
        chk("t3_dc", 32'(drop_count), 32'd2);
`endif
        repeat (8) handshake("t3_drain");
        chk("t3_last", 32'(frame_out), 32'h107);

        // Full with a simultaneous pop
        cycle("t4_flush", 0, '0, 1, 0);
        for (int i = 0; i < 8; i++) cycle("t4_fill", 1, 18'(18'h200 + i), 0, 0);
        cycle("t4_popush", 1, 18'h2FFFF, 0, 1);
        chk("t4_count8", 32'(fifo_count), 32'd8);
        chk("t4_ovf0", 32'(overflow), 32'd0);
        chk("t4_head", 32'(frame_out), 32'h200);

        // Flush while a frame is in flight
        cycle("t5_busy", 0, '0, 0, 0);
        cycle("t5_flush", 0, '0, 1, 0);
        chk("t5_count0", 32'(fifo_count), 32'd0);
        chk("t5_ovf0", 32'(overflow), 32'd0);
        cycle("t5_done", 0, '0, 0, 1);
        repeat (3) cycle("t5_quiet", 0, '0, 0, 1);
        chk("t5_no_ndr", 32'(new_data_ready), 32'd0);

        // Async reset while issuing
        cycle("t6_push", 1, 18'h3ABCD, 0, 1);
        cycle("t6_issue", 0, '0, 0, 1);
        chk("t6_in_issue", 32'(new_data_ready), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("t6_async_ndr", 32'(new_data_ready), 32'd0);
        chk("t6_async_frame", 32'(frame_out), 32'd0);
        check_all("t6_async");
        cycle("t6_hold", 0, '0, 0, 1);
        reset_n = 1'b1;
        cycle("t6_after", 1, 18'h0F0F0, 0, 1);
        cycle("t6_after_pop", 0, '0, 0, 1);
        chk("t6_frame", 32'(frame_out), 32'h0F0F0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", bit'($urandom_range(0, 1)), 18'($urandom),
                  $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
